// File: rtl/fnv_pkg.sv
// Shared FNV-1a constants, engine state encoding and the single-byte step function.
// Used by fnv1a_step_comb and fnv1a_hasher.
package fnv_pkg;

    localparam logic [31:0] FNV32_OFFSET = 32'h811C9DC5;
    localparam logic [31:0] FNV32_PRIME  = 32'h01000193;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } fnv_state_t;

    // The prime is 2^24 + 2^8 + 2^7 + 2^4 + 2^1 + 1, so the multiply becomes a shift-add tree.
    function automatic logic [31:0] fnv1a_step(input logic [31:0] acc, input logic [7:0] data);
        logic [31:0] x;
        x = acc ^ {24'h0, data};
        return x + (x << 24) + (x << 8) + (x << 7) + (x << 4) + (x << 1);
    endfunction

endpackage

// File: rtl/fnv1a_step_comb.sv
// Purely combinational single-byte FNV-1a step.
// Kept as its own module so the arithmetic can be exercised in isolation.
module fnv1a_step_comb
    import fnv_pkg::*;
(
    input  logic [31:0] i_acc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_next
);

    assign o_next = fnv1a_step(i_acc, i_data);

endmodule

// File: rtl/fnv1a_hasher.sv
// 32-bit FNV-1a engine: one byte per cycle in, finished hash held on a valid/ready output.
// Optional per-message byte counter enabled by defining FNV1A_BYTE_COUNT_EN.
module fnv1a_hasher
    import fnv_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 16
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        abort,
    output logic        hash_valid,
    input  logic        hash_ready,
    output logic [31:0] hash
`ifdef FNV1A_BYTE_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] byte_count
`endif
);

    if (COUNT_WIDTH < 1) begin : g_bad_width
        $error("fnv1a_hasher: COUNT_WIDTH must be at least 1");
    end

    fnv_state_t  r_state;
    fnv_state_t  w_state_next;
    logic [31:0] r_acc;
    logic [31:0] r_hash;
    logic [31:0] w_step;
    logic        w_accept;
    logic        w_release;
    logic        w_abort;

    fnv1a_step_comb u_step (
        .i_acc  (r_acc),
        .i_data (in_data),
        .o_next (w_step)
    );

    assign w_accept  = in_valid && in_ready;
    assign w_release = hash_valid && hash_ready;
    // A finished hash is never discarded, so abort only counts outside DONE.
    assign w_abort   = abort && (r_state != DONE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, ACCUM: begin
                if (w_abort) begin
                    w_state_next = IDLE;
                end else if (w_accept) begin
                    w_state_next = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (w_release) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b1;
        hash_valid = 1'b0;
        case (r_state)
            DONE: begin
                in_ready   = 1'b0;
                hash_valid = 1'b1;
            end
            default: begin
                in_ready   = 1'b1;
                hash_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc  <= FNV32_OFFSET;
            r_hash <= '0;
        end else if (w_abort || w_release) begin
            r_acc  <= FNV32_OFFSET;
        end else if (w_accept) begin
            r_acc <= w_step;
            if (in_last) begin
                r_hash <= w_step;
            end
        end
    end

    assign hash = r_hash;

`ifdef FNV1A_BYTE_COUNT_EN
    logic [COUNT_WIDTH-1:0] r_count;

    // Counter freezes in DONE (no bytes accepted), so it doubles as the latched result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_abort || w_release) begin
            r_count <= '0;
        end else if (w_accept && (r_count != '1)) begin
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

    assign byte_count = r_count;
`endif

endmodule

// File: tb/tb_fnv1a_hasher.sv
// Directed self-checking bench for fnv1a_hasher with an expected-hash scoreboard.
// Byte-count checks are active when FNV1A_BYTE_COUNT_EN is defined.
module tb_fnv1a_hasher;

    localparam int          CW     = 16;
    localparam logic [31:0] OFFSET = 32'h811C9DC5;
    localparam logic [31:0] PRIME  = 32'h01000193;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        in_valid   = 1'b0;
    logic [7:0]  in_data    = 8'h00;
    logic        in_last    = 1'b0;
    logic        abort      = 1'b0;
    logic        hash_ready = 1'b0;
    logic        in_ready;
    logic        hash_valid;
    logic [31:0] hash;
`ifdef FNV1A_BYTE_COUNT_EN
    logic [CW-1:0] byte_count;
`endif

    logic [31:0] t_acc  = 32'h0;
    logic [7:0]  t_data = 8'h0;
    logic [31:0] t_next;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_hash_q[$];
    int          exp_cnt_q[$];

    fnv1a_hasher #(.COUNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .abort      (abort),
        .hash_valid (hash_valid),
        .hash_ready (hash_ready),
        .hash       (hash)
`ifdef FNV1A_BYTE_COUNT_EN
        ,
        .byte_count (byte_count)
`endif
    );

    fnv1a_step_comb u_step_iso (
        .i_acc  (t_acc),
        .i_data (t_data),
        .o_next (t_next)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] a, input logic [7:0] d);
        return (a ^ {24'h0, d}) * PRIME;
    endfunction

    task automatic check_count(input string tag, input int exp);
`ifdef FNV1A_BYTE_COUNT_EN
        check(tag, 32'(byte_count), 32'(exp));
`else
        if (exp < 0) $display("note: negative count %0d for %s", exp, tag);
`endif
    endtask

    // Presents one byte (called at a negedge) and returns at the negedge after it is taken.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
    endtask

    task automatic send_msg(input string s, input bit bubbles);
        for (int i = 0; i < s.len(); i++) begin
            if (bubbles) begin
                for (int j = 0; j < 3 && $urandom_range(0, 1) == 1; j++) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            send_byte(s[i], i == s.len() - 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({s, "_latency_valid"}, {31'h0, hash_valid}, 32'h1);
        check({s, "_done_in_ready"}, {31'h0, in_ready}, 32'h0);
    endtask

    task automatic collect(input string tag);
        int          guard;
        logic [31:0] exp;
        int          exp_cnt;
        guard = 0;
        while (!hash_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!hash_valid) check({tag, "_valid_timeout"}, {31'h0, hash_valid}, 32'h1);
        exp     = exp_hash_q.pop_front();
        exp_cnt = exp_cnt_q.pop_front();
        check({tag, "_hash"}, hash, exp);
        check_count({tag, "_count"}, exp_cnt);
        hash_ready = 1'b1;
        @(negedge clk);
        hash_ready = 1'b0;
        check({tag, "_released_valid"}, {31'h0, hash_valid}, 32'h0);
        check({tag, "_released_ready"}, {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        // Arithmetic in isolation: known vector, extremes, random.
        t_acc = OFFSET; t_data = 8'h61; #1;
        check("step_a", t_next, 32'hE40C292C);
        t_acc = 32'hFFFF_FFFF; t_data = 8'hFF; #1;
        check("step_ff", t_next, model_step(t_acc, t_data));
        for (int k = 0; k < 4; k++) begin
            t_acc  = $urandom;
            t_data = 8'($urandom_range(0, 255));
            #1;
            check("step_rand", t_next, model_step(t_acc, t_data));
        end

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_hash_valid", {31'h0, hash_valid}, 32'h0);
        check("rst_hash", hash, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check_count("rst_count", 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

        // 1: single byte with consumer always ready.
        hash_ready = 1'b1;
        exp_hash_q.push_back(32'hE40C292C); exp_cnt_q.push_back(1);
        send_msg("a", 1'b0);
        collect("t1_a");

        // 2: back-to-back multi-byte message.
        exp_hash_q.push_back(32'hBF9CF968); exp_cnt_q.push_back(6);
        send_msg("foobar", 1'b0);
        collect("t2_foobar");

        // 3: stalled consumer, stray input and abort while DONE.
        exp_hash_q.push_back(32'hE70C2DE5); exp_cnt_q.push_back(1);
        send_msg("b", 1'b0);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h55;
            in_last  = 1'b1;
            abort    = (k == 2);
            @(negedge clk);
            check("t3_stall_hash", hash, 32'hE70C2DE5);
            check("t3_stall_valid", {31'h0, hash_valid}, 32'h1);
            check("t3_stall_ready", {31'h0, in_ready}, 32'h0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        abort    = 1'b0;
        collect("t3_b");
        exp_hash_q.push_back(32'hE40C292C); exp_cnt_q.push_back(1);
        send_msg("a", 1'b0);
        collect("t3_a");

        // 4: abort with a byte presented; the byte must be dropped.
        exp_hash_q.push_back(32'hE40C292C); exp_cnt_q.push_back(1);
        send_byte("f", 1'b0);
        send_byte("o", 1'b0);
        send_byte("o", 1'b0);
        in_valid = 1'b1;
        in_data  = "b";
        in_last  = 1'b0;
        abort    = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        check("t4_abort_valid", {31'h0, hash_valid}, 32'h0);
        check("t4_abort_ready", {31'h0, in_ready}, 32'h1);
        check_count("t4_abort_count", 0);
        send_msg("a", 1'b0);
        collect("t4_a");

        // 5: asynchronous reset mid-message.
        send_byte("f", 1'b0);
        send_byte("o", 1'b0);
        send_byte("o", 1'b0);
        reset_n = 1'b0;
        #1;
        check("t5_rst_hash", hash, 32'h0);
        check("t5_rst_valid", {31'h0, hash_valid}, 32'h0);
        check("t5_rst_ready", {31'h0, in_ready}, 32'h1);
        check_count("t5_rst_count", 0);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        exp_hash_q.push_back(32'hBF9CF968); exp_cnt_q.push_back(6);
        send_msg("foobar", 1'b0);
        collect("t5_foobar");

        // 6: random bubbles on in_valid.
        exp_hash_q.push_back(32'hBF9CF968); exp_cnt_q.push_back(6);
        send_msg("foobar", 1'b1);
        collect("t6_foobar_bubbles");

        check("scoreboard_empty", 32'(exp_hash_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
